// File: rtl/baby_pkg.sv
// Shared types and geometry for the INIT splash scanner.
// Contents:
//   state_e  - controller states (idle / scanning / one-cycle done)
//   seg_e    - which 16-dot ROM segment of a line is being emitted
//   DOT_COLS, DOT_ROWS, DOT_SEGS - dot-matrix geometry
package baby_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    SegLeft,
    SegCentre,
    SegRight
  } seg_e;

  localparam int unsigned DOT_COLS = 16;
  localparam int unsigned DOT_ROWS = 16;
  localparam int unsigned DOT_SEGS = 3;

endpackage

// File: rtl/init_scan_ctrl.sv
// INIT splash scan controller.
// Walks a 48x16 dot image (three 16-dot ROM segments per line) out as a
// serial pixel stream with valid/ready handshake, repeating the image for
// HOLD_FRAMES frames (or fewer if skip is requested), then pulses done.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   start                      - one-cycle request to begin the splash (idle only)
//   skip                       - end the splash at the next frame boundary
//   dot_x, dot_y               - ROM column/row address (zero when not scanning)
//   pixell, pixelc, pixelr     - combinational ROM outputs per segment
//   pix_data, pix_valid        - serial dot and its valid flag
//   pix_ready                  - consumer accepts the current dot
//   line_start, frame_start    - first dot of a line / of a frame
//   busy, done                 - scanning / one-cycle completion pulse
module init_scan_ctrl
  import baby_pkg::*;
#(
  parameter int unsigned HOLD_FRAMES = 50,
  parameter logic        IDLE_PIX    = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       skip,
  output logic [3:0] dot_x,
  output logic [3:0] dot_y,
  input  logic       pixell,
  input  logic       pixelc,
  input  logic       pixelr,
  output logic       pix_data,
  output logic       pix_valid,
  input  logic       pix_ready,
  output logic       line_start,
  output logic       frame_start,
  output logic       busy,
  output logic       done
);

  localparam int unsigned FrameW = $clog2(HOLD_FRAMES + 1);
  localparam logic [FrameW-1:0] LastFrame = FrameW'(HOLD_FRAMES - 1);
  localparam logic [3:0] ColLast = 4'(DOT_COLS - 1);
  localparam logic [3:0] RowLast = 4'(DOT_ROWS - 1);

  state_e            state_q, state_d;
  logic [3:0]        x_q, x_d;
  logic [3:0]        y_q, y_d;
  seg_e              seg_q, seg_d;
  logic [FrameW-1:0] frame_q, frame_d;
  logic              skip_q, skip_d;

  logic scanning;
  logic accept;
  logic frame_end;
  logic seg_pix;

  assign scanning  = (state_q == StScan);
  assign accept    = scanning && pix_ready;
  assign frame_end = (x_q == ColLast) && (seg_q == SegRight) && (y_q == RowLast);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    seg_d   = seg_q;
    frame_d = frame_q;
    skip_d  = skip_q;
    unique case (state_q)
      StIdle: begin
        // Skip arriving with start belongs to no splash yet, so it is dropped.
        if (start) begin
          state_d = StScan;
          x_d     = '0;
          y_d     = '0;
          seg_d   = SegLeft;
          frame_d = '0;
          skip_d  = 1'b0;
        end
      end
      StScan: begin
        skip_d = skip_q | skip;
        if (accept) begin
          if (x_q != ColLast) begin
            x_d = x_q + 4'd1;
          end else begin
            x_d = '0;
            case (seg_q)
              SegLeft:   seg_d = SegCentre;
              SegCentre: seg_d = SegRight;
              default: begin
                seg_d = SegLeft;
                y_d   = y_q + 4'd1;
              end
            endcase
          end
          if (frame_end) begin
            frame_d = frame_q + 1'b1;
            // A skip seen on this very cycle still counts for this frame.
            if (skip_q || skip || (frame_q == LastFrame)) begin
              state_d = StDone;
            end
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      seg_q   <= SegLeft;
      frame_q <= '0;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      seg_q   <= seg_d;
      frame_q <= frame_d;
      skip_q  <= skip_d;
    end
  end

  // ROM is combinational, so the selected segment bit goes straight out.
  always_comb begin
    case (seg_q)
      SegLeft:   seg_pix = pixell;
      SegCentre: seg_pix = pixelc;
      default:   seg_pix = pixelr;
    endcase
  end

  assign busy        = scanning;
  assign pix_valid   = scanning;
  assign done        = (state_q == StDone);
  assign dot_x       = scanning ? x_q : 4'd0;
  assign dot_y       = scanning ? y_q : 4'd0;
  assign pix_data    = scanning ? seg_pix : IDLE_PIX;
  assign line_start  = scanning && (x_q == 4'd0) && (seg_q == SegLeft);
  assign frame_start = line_start && (y_q == 4'd0);

endmodule

// File: doc/init_scan_ctrl.md
INIT_SCAN_CTRL -- requirements
Module: init_scan_ctrl

Interface
REQ-001 SHALL have parameter HOLD_FRAMES, default 50: number of complete frames shown before done.
REQ-002 SHALL have parameter IDLE_PIX, default 1'b0: value driven on pix_data when not scanning.
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin the INIT splash.
REQ-006 SHALL have port skip  input  1  request to end the splash at the next frame boundary.
REQ-007 SHALL have port dot_x  output  4  column address to the INIT dot ROM.
REQ-008 SHALL have port dot_y  output  4  row address to the INIT dot ROM.
REQ-009 SHALL have ports pixell, pixelc, pixelr  input  1 each  combinational ROM outputs (left/centre/right 16-dot segments).
REQ-010 SHALL have port pix_data  output  1  current serial dot.
REQ-011 SHALL have port pix_valid  output  1  pix_data is valid.
REQ-012 SHALL have port pix_ready  input  1  consumer accepts pix_data this cycle.
REQ-013 SHALL have ports line_start, frame_start  output  1 each  high with the first dot of each line / frame.
REQ-014 SHALL have ports busy, done  output  1 each  splash in progress / one-cycle completion pulse.

Function
REQ-015 SHALL implement states IDLE, SCAN, DONE; DONE lasts exactly one cycle, then IDLE.
REQ-016 SHALL move IDLE->SCAN on the cycle after start=1; pix_valid first high on that cycle with dot_x=0, dot_y=0, segment=left, frame count 0.
REQ-017 SHALL ignore start while in SCAN or DONE.
REQ-018 SHALL scan each line as 48 dots: segment left x=0..15, then centre x=0..15, then right x=0..15; rows y=0..15 in order.
REQ-019 SHALL drive pix_data = pixell/pixelc/pixelr selected by current segment, same cycle (zero latency through ROM).
REQ-020 SHALL advance position only on pix_valid && pix_ready; otherwise hold dot_x, dot_y, segment and pix_data stable.
REQ-021 SHALL wrap x 15->0 advancing segment; right segment x=15 wraps to left, y+1; y=15 wraps to 0, frame count +1.
REQ-022 SHALL assert line_start when x=0, segment=left, pix_valid=1; frame_start additionally when y=0.
REQ-023 SHALL, on acceptance of the last dot of frame HOLD_FRAMES-1, enter DONE (done=1, pix_valid=0).
REQ-024 SHALL latch skip (sticky) during SCAN and enter DONE on acceptance of the last dot of the current frame; skip with start in IDLE is ignored.
REQ-025 SHALL count frames in ceil(log2(HOLD_FRAMES+1)) bits; HOLD_FRAMES=1 yields exactly one frame.
REQ-026 SHALL drive busy=1 in SCAN only; pix_data=IDLE_PIX and dot_x=dot_y=0 outside SCAN.

Reset
REQ-027 SHALL, with reset=1 at a clock edge, enter IDLE: pix_valid=0, done=0, busy=0, line_start=0, frame_start=0, counters and skip latch 0, regardless of state.
REQ-028 SHALL give reset priority over start and skip in the same cycle.

Structure
REQ-029 SHALL place state enum, DOT_COLS=16, DOT_ROWS=16, DOT_SEGS=3 in shared package baby_pkg.
REQ-030 SHALL be a single module; no sub-module required, counters inline.

Verification
REQ-031 HOLD_FRAMES=2, pix_ready=1, start pulse -> exactly 2*768=1536 accepted dots, done high one cycle after last, busy low after.
REQ-032 ROM model, row 1 (left segment 000000111111...), pix_ready=1 -> first pix_data=1 at dot 6 of line 1; line_start every 48 dots.
REQ-033 pix_ready toggled 1/0 every cycle -> dot_x/dot_y/pix_data stable across stalls; total 1536 accepts for HOLD_FRAMES=2.
REQ-034 skip pulsed at dot 100 of frame 0, HOLD_FRAMES=50 -> done after dot 768, frame count 1.
REQ-035 reset asserted at dot 300 -> next cycle IDLE, all outputs at reset values; fresh start restarts at x=0,y=0.
REQ-036 second start during SCAN -> no restart, dot sequence unchanged.
